// File: rtl/deserializer_multilane.sv
// rtl/deserializer_multilane.sv - multi-lane beat-to-word deserializer with one-word output register
module deserializer_multilane #(
  parameter int WORD_LEN  = 24,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_flush,
  input  logic [LANES-1:0]    iv_din,
  input  logic                i_din_valid,
  output logic                o_ready,
  output logic [WORD_LEN-1:0] ov_dout,
  output logic                o_dout_valid,
  input  logic                i_ready,
  output logic                o_overrun
);

  localparam int BEATS = WORD_LEN / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       cnt;
  logic [WORD_LEN-1:0] sreg;
  logic [WORD_LEN-1:0] sreg_ins;
  logic                accept;
  logic                consume;
  logic                final_beat;
  logic                out_free;
  logic                load_direct;
  logic                load_hold;
  logic                load_word;
  logic [WORD_LEN-1:0] load_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (i_en) begin
      if (i_flush) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE, SHIFT: begin
            if (final_beat) begin
              state_nxt = out_free ? IDLE : HOLD;
            end else if (accept) begin
              state_nxt = SHIFT;
            end
          end
          HOLD: begin
            if (consume) begin
              state_nxt = IDLE;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // A finished word bypasses HOLD whenever the output register is empty or draining this cycle.
  always_comb begin
    o_ready     = i_en && (state != HOLD);
    accept      = o_ready && i_din_valid && !i_flush;
    consume     = i_en && i_ready && o_dout_valid;
    final_beat  = accept && (cnt == LAST_BEAT);
    out_free    = !o_dout_valid || consume;
    load_direct = final_beat && out_free;
    load_hold   = (state == HOLD) && consume && !i_flush;
    load_word   = load_direct || load_hold;
    load_data   = load_hold ? sreg : sreg_ins;
  end

  always_comb begin
    sreg_ins = sreg;
    for (int b = 0; b < BEATS; b++) begin
      if (cnt == CW'(b)) begin
        sreg_ins[(MSB_FIRST ? (BEATS - 1 - b) : b) * LANES +: LANES] = iv_din;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt  <= '0;
      sreg <= '0;
    end else if (i_en) begin
      if (i_flush || load_word) begin
        cnt  <= '0;
        sreg <= '0;
      end else if (accept) begin
        sreg <= sreg_ins;
        cnt  <= (cnt == LAST_BEAT) ? '0 : cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_dout      <= '0;
      o_dout_valid <= 1'b0;
      o_overrun    <= 1'b0;
    end else if (i_en) begin
      if (load_word) begin
        ov_dout      <= load_data;
        o_dout_valid <= 1'b1;
      end else if (consume) begin
        o_dout_valid <= 1'b0;
      end
      if (i_din_valid && !o_ready) begin
        o_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_deserializer_multilane.sv
// tb/tb_deserializer_multilane.sv - scoreboard bench for two deserializer_multilane configurations
module tb_deserializer_multilane;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_en, a_flush, a_vld, a_rdy_dn, a_ready, a_dvalid, a_ovr;
  logic [0:0]  a_din;
  logic [23:0] a_dout;
  logic        b_en, b_flush, b_vld, b_rdy_dn, b_ready, b_dvalid, b_ovr;
  logic [3:0]  b_din;
  logic [23:0] b_dout;

  int passed = 0;
  int total  = 0;
  logic [23:0] qa[$];
  logic [23:0] qb[$];
  bit rnd_a = 1'b0;
  bit rnd_b = 1'b0;

  deserializer_multilane #(.WORD_LEN(24), .LANES(1), .MSB_FIRST(1'b0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(a_en), .i_flush(a_flush),
    .iv_din(a_din), .i_din_valid(a_vld), .o_ready(a_ready), .ov_dout(a_dout),
    .o_dout_valid(a_dvalid), .i_ready(a_rdy_dn), .o_overrun(a_ovr)
  );

  deserializer_multilane #(.WORD_LEN(24), .LANES(4), .MSB_FIRST(1'b1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(b_en), .i_flush(b_flush),
    .iv_din(b_din), .i_din_valid(b_vld), .o_ready(b_ready), .ov_dout(b_dout),
    .o_dout_valid(b_dvalid), .i_ready(b_rdy_dn), .o_overrun(b_ovr)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endtask

  task automatic chk24(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %06h expected %06h", name, act, exp);
  endtask

  // Monitors: a word is consumed on the next edge whenever enable, downstream ready and valid coincide.
  always @(negedge clk) begin : mon_a
    logic [23:0] e;
    if (rst_n && a_en && a_rdy_dn && a_dvalid) begin
      if (qa.size() == 0) begin
        total++;
        $display("FAIL a_unexpected_word: got %06h expected no word", a_dout);
      end else begin
        e = qa.pop_front();
        chk24("a_word", a_dout, e);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [23:0] e;
    if (rst_n && b_en && b_rdy_dn && b_dvalid) begin
      if (qb.size() == 0) begin
        total++;
        $display("FAIL b_unexpected_word: got %06h expected no word", b_dout);
      end else begin
        e = qb.pop_front();
        chk24("b_word", b_dout, e);
      end
    end
  end

  // Drivers are entered and left at posedge+1.
  task automatic a_beat(input logic bitv);
    int n = 0;
    while (!a_ready && n < 200) begin
      a_vld = 1'b0;
      if (rnd_a) a_rdy_dn = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    if (!a_ready) begin
      total++;
      $display("FAIL a_ready_timeout: got ready %0b expected 1", a_ready);
    end
    a_din = bitv;
    a_vld = 1'b1;
    if (rnd_a) a_rdy_dn = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    a_vld = 1'b0;
  endtask

  task automatic a_bits(input logic [23:0] w, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) a_beat(w[k]);
  endtask

  task automatic a_word(input logic [23:0] w);
    qa.push_back(w);
    a_bits(w, 0, 23);
  endtask

  task automatic b_beat(input logic [3:0] d);
    int n = 0;
    while (!b_ready && n < 200) begin
      b_vld = 1'b0;
      if (rnd_b) b_rdy_dn = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    if (!b_ready) begin
      total++;
      $display("FAIL b_ready_timeout: got ready %0b expected 1", b_ready);
    end
    b_din = d;
    b_vld = 1'b1;
    if (rnd_b) b_rdy_dn = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    b_vld = 1'b0;
  endtask

  // High-nibble-first: the first beat carries the top four bits of the word.
  task automatic b_word(input logic [23:0] w);
    qb.push_back(w);
    for (int k = 0; k < 6; k++) b_beat(w[(5 - k) * 4 +: 4]);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] w, x, y, w1, w2, p, q;
    int nb;
    rst_n = 1'b0;
    a_en = 1'b1; a_flush = 1'b0; a_din = '0; a_vld = 1'b0; a_rdy_dn = 1'b1;
    b_en = 1'b1; b_flush = 1'b0; b_din = '0; b_vld = 1'b0; b_rdy_dn = 1'b1;
    #12;
    chk24("reset_dout", a_dout, 24'h0);
    chk1("reset_valid", a_dvalid, 1'b0);
    chk1("reset_overrun", a_ovr, 1'b0);
    chk1("reset_b_valid", b_dvalid, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-lane LSB-first word with one-cycle latency
    w = 24'hA5C3F0;
    qa.push_back(w);
    a_bits(w, 0, 22);
    chk1("lat_valid_before_last", a_dvalid, 1'b0);
    a_beat(w[23]);
    chk1("lat_valid_after_last", a_dvalid, 1'b1);
    chk24("lat_dout_a5c3f0", a_dout, 24'hA5C3F0);
    cycles(1);
    chk1("lat_valid_one_cycle", a_dvalid, 1'b0);

    // Enable low mid-word while an output word is pending
    a_rdy_dn = 1'b0;
    x = 24'($urandom);
    y = 24'($urandom);
    a_word(x);
    qa.push_back(y);
    a_bits(y, 0, 11);
    a_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_vld = 1'(i % 2);
      a_rdy_dn = 1'((i + 1) % 2);
      a_flush = 1'(i / 2 % 2);
      a_din = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    chk1("en_low_ready", a_ready, 1'b0);
    chk1("en_low_valid", a_dvalid, 1'b1);
    chk24("en_low_dout", a_dout, x);
    chk1("en_low_overrun", a_ovr, 1'b0);
    a_en = 1'b1; a_vld = 1'b0; a_flush = 1'b0; a_rdy_dn = 1'b1;
    a_bits(y, 12, 23);
    chk24("en_resume_dout", a_dout, y);
    cycles(2);

    // Flush after 10 beats of ones, flush beats a same-cycle data beat
    a_bits(24'hFFFFFF, 0, 9);
    a_flush = 1'b1; a_vld = 1'b1; a_din = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0; a_vld = 1'b0;
    a_word(24'h000001);
    chk24("flush_dout", a_dout, 24'h000001);
    cycles(2);

    // Back-pressure: first word in output register, second in HOLD, then overrun
    a_rdy_dn = 1'b0;
    w1 = 24'($urandom);
    w2 = 24'($urandom);
    a_word(w1);
    a_word(w2);
    chk1("hold_ready_low", a_ready, 1'b0);
    chk1("hold_valid", a_dvalid, 1'b1);
    chk24("hold_dout_first", a_dout, w1);
    chk1("hold_no_overrun_yet", a_ovr, 1'b0);
    a_vld = 1'b1;
    @(posedge clk); #1;
    a_vld = 1'b0;
    chk1("overrun_set", a_ovr, 1'b1);
    a_rdy_dn = 1'b1;
    cycles(1);
    chk24("hold_dout_second", a_dout, w2);
    chk1("hold_valid_kept", a_dvalid, 1'b1);
    chk1("hold_ready_back", a_ready, 1'b1);
    cycles(1);
    chk1("hold_drained", a_dvalid, 1'b0);
    chk1("overrun_sticky", a_ovr, 1'b1);

    // Asynchronous reset mid-word with a pending output word
    a_rdy_dn = 1'b0;
    p = 24'($urandom);
    q = 24'($urandom);
    a_word(p);
    a_bits(q, 0, 7);
    #3;
    rst_n = 1'b0;
    #1;
    chk24("async_rst_dout", a_dout, 24'h0);
    chk1("async_rst_valid", a_dvalid, 1'b0);
    chk1("async_rst_overrun", a_ovr, 1'b0);
    qa.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    a_rdy_dn = 1'b1;
    w = 24'($urandom);
    a_word(w);
    chk24("post_rst_dout", a_dout, w);
    cycles(2);

    // Randomised traffic with random back-pressure and occasional flushed fragments
    rnd_a = 1'b1;
    repeat (25) begin
      if ($urandom_range(0, 3) == 0) begin
        nb = $urandom_range(0, 22);
        a_bits(24'($urandom), 0, nb);
        a_flush = 1'b1;
        a_vld = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        a_flush = 1'b0; a_vld = 1'b0;
      end
      a_word(24'($urandom));
    end
    rnd_a = 1'b0;
    a_rdy_dn = 1'b1;
    cycles(5);
    total++;
    if (qa.size() == 0) passed++;
    else $display("FAIL a_queue_drained: got %0d pending expected 0", qa.size());

    // Four-lane, high-beat-first configuration
    b_word(24'h123456);
    chk24("b_dout_123456", b_dout, 24'h123456);
    chk1("b_valid_123456", b_dvalid, 1'b1);
    rnd_b = 1'b1;
    repeat (15) b_word(24'($urandom));
    rnd_b = 1'b0;
    b_rdy_dn = 1'b1;
    cycles(5);
    total++;
    if (qb.size() == 0) passed++;
    else $display("FAIL b_queue_drained: got %0d pending expected 0", qb.size());
    chk1("b_no_overrun", b_ovr, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/deserializer_multilane.md
DESERIALIZER_MULTILANE -- requirements
Module: deserializer_multilane

Interface
REQ-001 SHALL have parameter WORD_LEN, default 24, output word width in bits.
REQ-002 SHALL have parameter LANES, default 1, input bits per accepted beat; WORD_LEN % LANES == 0, LANES >= 1; BEATS = WORD_LEN/LANES.
REQ-003 SHALL have parameter MSB_FIRST, default 0; 0 = first beat fills the low bits, 1 = first beat fills the high bits.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_en, input, 1, clock enable; low freezes all state and handshakes.
REQ-007 SHALL have port i_flush, input, 1, synchronous discard of the partial or pending word.
REQ-008 SHALL have port iv_din, input, LANES, beat data.
REQ-009 SHALL have port i_din_valid, input, 1, upstream beat valid.
REQ-010 SHALL have port o_ready, output, 1, block able to accept a beat this cycle.
REQ-011 SHALL have port ov_dout, output, WORD_LEN, assembled word.
REQ-012 SHALL have port o_dout_valid, output, 1, ov_dout holds an unconsumed word.
REQ-013 SHALL have port i_ready, input, 1, downstream ready.
REQ-014 SHALL have port o_overrun, output, 1, sticky flag: i_din_valid was high while o_ready was low and i_en was high.

Function
REQ-015 SHALL accept a beat only when i_en && i_din_valid && o_ready && !i_flush.
REQ-016 SHALL implement states IDLE (no partial word), SHIFT (1..BEATS-1 beats held) and HOLD (complete word waiting for the output register).
REQ-017 SHALL drive o_ready combinationally as i_en && (state != HOLD).
REQ-018 SHALL place beat k (k = 0..BEATS-1) at bits [k*LANES +: LANES] when MSB_FIRST=0, and at [(BEATS-1-k)*LANES +: LANES] when MSB_FIRST=1; iv_din bit order is preserved within a beat.
REQ-019 SHALL count accepted beats with a counter of max(1, $clog2(BEATS)) bits that wraps to 0 after beat BEATS-1.
REQ-020 SHALL take IDLE->SHIFT on an accepted beat when BEATS>1; with BEATS==1 the beat completes the word directly.
REQ-021 SHALL, on the accepted final beat, load ov_dout and set o_dout_valid on the next edge if the output register is empty or is being consumed in the same cycle (i_ready && o_dout_valid), then go to IDLE; otherwise go to HOLD.
REQ-022 SHALL, in HOLD, transfer the shift word to ov_dout on the cycle the output is consumed and return to IDLE; o_ready stays low during that cycle.
REQ-023 SHALL clear o_dout_valid when i_ready && o_dout_valid && i_en, unless a new word loads in the same cycle, in which case valid stays high and ov_dout updates.
REQ-024 SHALL hold ov_dout stable while o_dout_valid is high and not consumed.
REQ-025 SHALL make latency from the accepted final beat to o_dout_valid exactly 1 cycle when the output path is free.
REQ-026 SHALL, on i_flush with i_en high, clear the shift register and beat counter and go to IDLE, taking priority over a same-cycle beat; the output register and o_dout_valid are unaffected.
REQ-027 SHALL ignore i_flush, i_ready and i_din_valid while i_en is low, with no state, counter, output or o_overrun change.
REQ-028 SHALL clear o_overrun only by reset.

Reset
REQ-029 SHALL, while i_rst_n is low, immediately force state=IDLE, counter=0, shift register=0, ov_dout=0, o_dout_valid=0, o_overrun=0.
REQ-030 SHALL discard a partial word when reset asserts mid-word; the first accepted beat after release is beat 0.

Verification
REQ-031 SHALL cover: LANES=1, WORD_LEN=24, MSB_FIRST=0, 24 bits of 0xA5C3F0 sent LSB first, i_ready=1 -> ov_dout=0xA5C3F0, o_dout_valid high exactly 1 cycle after the 24th beat.
REQ-032 SHALL cover: LANES=4, WORD_LEN=24, MSB_FIRST=1, beats 0x1,0x2,0x3,0x4,0x5,0x6 -> ov_dout=0x123456 after 6 beats.
REQ-033 SHALL cover: i_ready=0 while two words are sent back-to-back -> first word is held in ov_dout, second enters HOLD, o_ready low, an extra valid beat sets o_overrun=1; raising i_ready yields both words in order, none lost.
REQ-034 SHALL cover: i_flush after 10 of 24 beats, then a full 0x000001 word -> output 0x000001, no residue of the flushed bits.
REQ-035 SHALL cover: i_rst_n pulsed low asynchronously mid-word and while o_dout_valid=1 -> all outputs 0 immediately; the next full word is assembled correctly.
REQ-036 SHALL cover: i_en low for 5 cycles mid-word with i_din_valid toggling -> counter, shift register and outputs unchanged; the word completes correctly once i_en returns high.
